// File: rtl/time_display_scan_if.sv
// Time-field and display-drive bundle between the timekeeping block and the
// multiplexed 7-segment scanner. The timekeeper side is the master; the
// scanner consumes the time fields and drives the display lines.
interface time_display_scan_if;
    logic [5:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
    logic [1:0] mode;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output hours,
        output mins,
        output secs,
        output mode,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  hours,
        input  mins,
        input  secs,
        input  mode,
        output an,
        output seg,
        output dp
    );
endinterface

// File: rtl/time_display_scan.sv
// Six-digit HH.MM.SS multiplexed 7-segment scanner.
// Snapshots the time fields once per frame so a digit pair never tears,
// converts each field to BCD, blinks the field selected for setting and
// drives one digit at a time through a registered output stage.
module time_display_scan #(
    parameter int SCAN_DIV   = 50_000,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int ACTIVE_LOW = 1
) (
    input logic                 clk,
    input logic                 reset,
    time_display_scan_if.slave  bus
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    // Output polarity: XOR mask applied only at the output register.
    localparam logic POL = (ACTIVE_LOW != 0);

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Scan / blink timing state.
    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [2:0]         idx_q,       idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q,  blink_ph_d;

    // Frame snapshot of the time fields.
    logic [5:0] snap_h_q, snap_h_d;
    logic [5:0] snap_m_q, snap_m_d;
    logic [5:0] snap_s_q, snap_s_d;

    // Registered display drive (already in pin polarity).
    logic [5:0] an_q,  an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q,  dp_d;

    logic scan_wrap;
    logic blink_wrap;
    logic frame_end;

    // Decode intermediates for the currently scanned digit.
    logic [5:0] field_val;
    logic       field_bad;
    logic [7:0] field_bcd;
    logic [3:0] digit;
    logic       blank;
    logic [5:0] an_raw;
    logic [6:0] seg_raw;
    logic       dp_raw;

    // Binary 0..63 to packed {tens, ones}; only meaningful for 0..59.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        int tens;
        int ones;
        tens = int'(v) / 10;
        ones = int'(v) % 10;
        return {4'(tens), 4'(ones)};
    endfunction

    // Active-high segment pattern {g,f,e,d,c,b,a} for a decimal digit.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Digit-hold counter, digit index and the frame-boundary snapshot.
    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_LAST);
        frame_end  = scan_wrap && (idx_q == 3'd5);

        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;

        idx_d = idx_q;
        if (scan_wrap) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        snap_h_d = snap_h_q;
        snap_m_d = snap_m_q;
        snap_s_d = snap_s_q;
        if (frame_end) begin
            snap_h_d = bus.hours;
            snap_m_d = bus.mins;
            snap_s_d = bus.secs;
        end
    end

    // Free-running blink half-period timer and phase.
    always_comb begin
        blink_wrap  = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_ph_d  = blink_wrap ? ~blink_ph_q : blink_ph_q;
    end

    // Select the field for the scanned digit, decode it and apply blanking.
    always_comb begin
        field_val = snap_s_q;
        field_bad = 1'b0;
        case (idx_q)
            3'd0, 3'd1: begin
                field_val = snap_s_q;
                field_bad = (snap_s_q > 6'd59);
            end
            3'd2, 3'd3: begin
                field_val = snap_m_q;
                field_bad = (snap_m_q > 6'd59);
            end
            3'd4, 3'd5: begin
                field_val = snap_h_q;
                field_bad = (snap_h_q > 6'd23);
            end
            default: begin
                field_val = 6'd0;
                field_bad = 1'b0;
            end
        endcase

        field_bcd = to_bcd(field_val);
        digit     = idx_q[0] ? field_bcd[7:4] : field_bcd[3:0];

        // Field number is idx/2 (0 secs, 1 mins, 2 hours); mode selects field+1.
        blank = blink_ph_q && (bus.mode != 2'b00) &&
                (bus.mode == 2'(idx_q[2:1] + 2'd1));

        an_raw  = 6'b000001 << idx_q;
        seg_raw = field_bad ? SEG_DASH : seg_code(digit);
        dp_raw  = (idx_q == 3'd2) || (idx_q == 3'd4);

        if (blank) begin
            an_raw  = 6'b000000;
            seg_raw = SEG_BLANK;
            dp_raw  = 1'b0;
        end

        an_d  = an_raw  ^ {6{POL}};
        seg_d = seg_raw ^ {7{POL}};
        dp_d  = dp_raw  ^ POL;
    end

    // State and output registers; synchronous reset leaves the display dark.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q  <= '0;
            idx_q       <= 3'd0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            snap_h_q    <= 6'd0;
            snap_m_q    <= 6'd0;
            snap_s_q    <= 6'd0;
            an_q        <= {6{POL}};
            seg_q       <= {7{POL}};
            dp_q        <= POL;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            snap_h_q    <= snap_h_d;
            snap_m_q    <= snap_m_d;
            snap_s_q    <= snap_s_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan with SCAN_DIV=4, BLINK_DIV=16,
// active-low outputs. Expected digits per frame are hand-entered; the slot
// index and blink phase follow from the clock count since reset release.
module tb_time_display_scan;

    logic clk;
    logic reset;
    int   k;
    int   n_vec;
    int   n_err;

    time_display_scan_if bus ();

    time_display_scan #(
        .SCAN_DIV   (4),
        .BLINK_DIV  (16),
        .ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Active-high segment code for a hand-entered digit; 10 means dash.
    function automatic logic [6:0] code(input int d);
        case (d)
            0:  return 7'h3F;
            1:  return 7'h06;
            2:  return 7'h5B;
            3:  return 7'h4F;
            4:  return 7'h66;
            5:  return 7'h6D;
            6:  return 7'h7D;
            7:  return 7'h07;
            8:  return 7'h7F;
            9:  return 7'h6F;
            10: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    // Digits listed left to right as shown on the display: H1 H0 M1 M0 S1 S0.
    function automatic logic [41:0] pack(input int d5, input int d4, input int d3,
                                         input int d2, input int d1, input int d0);
        return {code(d5), code(d4), code(d3), code(d2), code(d1), code(d0)};
    endfunction

    task automatic check_dark(input string tag);
        check_val({tag, "_an"},  {2'b00, bus.an},  8'h3F);
        check_val({tag, "_seg"}, {1'b0, bus.seg},  8'h7F);
        check_val({tag, "_dp"},  {7'b0, bus.dp},   8'h01);
    endtask

    // Run n clocks checking every output; after the sample at tick chg_t the
    // inputs are changed to the given values (chg_t < 0: no change).
    task automatic run(input string tag, input logic [41:0] e, input int n, input int chg_t,
                       input logic [5:0] nh, input logic [5:0] nm, input logic [5:0] ns,
                       input logic [1:0] nmd);
        int         di;
        int         ph;
        logic       blank;
        logic [5:0] oh;
        logic [5:0] ea;
        logic [6:0] es;
        logic       ed;
        for (int t = 0; t < n; t++) begin
            tick();
            k++;
            di    = ((k - 1) / 4) % 6;
            ph    = ((k - 1) / 16) % 2;
            blank = (ph == 1) && (bus.mode != 2'b00) && ((di / 2) == int'(bus.mode) - 1);
            oh    = 6'b000001 << di;
            if (blank) begin
                ea = 6'h3F;
                es = 7'h7F;
                ed = 1'b1;
            end else begin
                ea = ~oh;
                es = ~e[di*7 +: 7];
                ed = !((di == 2) || (di == 4));
            end
            check_val({tag, "_an"},  {2'b00, bus.an}, {2'b00, ea});
            check_val({tag, "_seg"}, {1'b0, bus.seg}, {1'b0, es});
            check_val({tag, "_dp"},  {7'b0, bus.dp},  {7'b0, ed});
            if (t == chg_t) begin
                bus.hours = nh;
                bus.mins  = nm;
                bus.secs  = ns;
                bus.mode  = nmd;
            end
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        k         = 0;
        reset     = 1'b1;
        bus.hours = 6'd23;
        bus.mins  = 6'd59;
        bus.secs  = 6'd7;
        bus.mode  = 2'b00;

        repeat (3) begin
            tick();
            check_dark("reset");
        end
        reset = 1'b0;

        // First frame shows the reset snapshot 00.00.00.
        run("frame0", pack(0, 0, 0, 0, 0, 0), 24, -1, 6'd23, 6'd59, 6'd7, 2'b00);
        bus.secs = 6'd12;

        // 23.59.07 loaded at the end of the first frame.
        run("basic", pack(2, 3, 5, 9, 0, 7), 24, -1, 6'd23, 6'd59, 6'd12, 2'b00);

        // 23.59.12 snapped; mins/secs change while the mins-tens digit is up.
        run("tear_a", pack(2, 3, 5, 9, 1, 2), 24, 12, 6'd23, 6'd34, 6'd13, 2'b00);

        // New values appear only from the next frame.
        run("tear_b", pack(2, 3, 3, 4, 1, 3), 24, 0, 6'd24, 6'd60, 6'd45, 2'b00);

        // Out-of-range hours and minutes give dashes; secs unaffected.
        run("range", pack(10, 10, 10, 10, 4, 5), 24, 0, 6'd9, 6'd8, 6'd30, 2'b00);
        bus.mode = 2'b10;

        // Minutes field blinks while the blink phase is high.
        run("blink_a", pack(0, 9, 0, 8, 3, 0), 24, -1, 6'd9, 6'd8, 6'd30, 2'b10);
        run("blink_b", pack(0, 9, 0, 8, 3, 0), 24, -1, 6'd9, 6'd8, 6'd30, 2'b10);

        // Back to run mode in the middle of a blanked minutes slot.
        run("blink_off", pack(0, 9, 0, 8, 3, 0), 24, 9, 6'd9, 6'd8, 6'd30, 2'b00);

        // Stop with the hours-ones digit on the display, then reset mid-frame.
        run("pre_rst", pack(0, 9, 0, 8, 3, 0), 17, -1, 6'd9, 6'd8, 6'd30, 2'b00);
        reset = 1'b1;
        tick();
        check_dark("mid_rst");
        bus.mode = 2'b01;
        tick();
        check_dark("mid_rst2");
        reset = 1'b0;
        k     = 0;

        // Snapshot cleared and blink phase restarts low.
        run("post_rst", pack(0, 0, 0, 0, 0, 0), 24, -1, 6'd9, 6'd8, 6'd30, 2'b01);
        run("post_rst2", pack(0, 9, 0, 8, 3, 0), 24, -1, 6'd9, 6'd8, 6'd30, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
